// File: rtl/acquisition_scheduler.sv
// Capture sequencer for the multi-channel input buffer (sink_clk domain).
// Issues periodic one-cycle start pulses, blocks starts while a capture is
// running or the buffer is not ready, and tracks completed / skipped frames.
module acquisition_scheduler #(
    parameter int LENGTH   = 2048,
    parameter int PERIOD_W = 16,
    parameter int FRAMES_W = 16,
    parameter int SKIP_W   = 8
) (
    input  logic                sink_clk,
    input  logic                reset_n,
    input  logic                arm,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [FRAMES_W-1:0] cfg_frames,
    input  logic                buf_ready,
    output logic                sink_start,
    output logic                capturing,
    output logic                busy,
    output logic                done,
    output logic [FRAMES_W-1:0] frame_cnt,
    output logic [SKIP_W-1:0]   skip_cnt,
    output logic                overrun
);

    localparam int            CW    = $clog2(LENGTH);
    localparam logic [CW-1:0] CLAST = CW'(LENGTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, START, CAPTURE} state_t;

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] pcnt, p_lat;
    logic [FRAMES_W-1:0] f_lat, frame_nxt;
    logic [CW-1:0]       ccnt;
    logic                tick, last_cap, run_done, skip_evt, arm_ok;

    assign tick      = (pcnt == '0) && (state != IDLE);
    assign last_cap  = (state == CAPTURE) && (ccnt == '0);
    assign frame_nxt = frame_cnt + FRAMES_W'(1);
    assign run_done  = last_cap && (f_lat != '0) && (frame_nxt == f_lat);
    // A tick that cannot launch a capture is lost; there is no late start.
    assign skip_evt  = tick && ((state == START) || (state == CAPTURE) ||
                                ((state == ARMED) && !buf_ready));
    assign arm_ok    = (state == IDLE) && arm && !abort;

    // State register
    always_ff @(posedge sink_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; abort overrides everything, including a same-cycle arm
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (arm) state_nxt = ARMED;
                ARMED:   if (tick && buf_ready) state_nxt = START;
                START:   state_nxt = CAPTURE;
                CAPTURE: if (last_cap) state_nxt = run_done ? IDLE : ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Moore outputs decoded straight from the state register
    always_comb begin
        sink_start = (state == START);
        capturing  = (state == CAPTURE);
        busy       = (state != IDLE);
    end

    // Period / capture counters, run configuration and frame statistics
    always_ff @(posedge sink_clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt      <= '0;
            p_lat     <= '0;
            f_lat     <= '0;
            ccnt      <= '0;
            done      <= 1'b0;
            frame_cnt <= '0;
            skip_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            done <= run_done && !abort;

            // Period counter restarts at 0 on every entry into a run
            if ((state == IDLE) || (state_nxt == IDLE))
                pcnt <= '0;
            else if (pcnt == p_lat - PERIOD_W'(1))
                pcnt <= '0;
            else
                pcnt <= pcnt + PERIOD_W'(1);

            if (state == START)
                ccnt <= CLAST;
            else if ((state == CAPTURE) && (ccnt != '0))
                ccnt <= ccnt - CW'(1);

            if (arm_ok) begin
                p_lat     <= (cfg_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cfg_period;
                f_lat     <= cfg_frames;
                frame_cnt <= '0;
                skip_cnt  <= '0;
                overrun   <= 1'b0;
            end else if (!abort) begin
                if (last_cap) frame_cnt <= frame_nxt;
                if (skip_evt) begin
                    overrun <= 1'b1;
                    if (skip_cnt != '1) skip_cnt <= skip_cnt + SKIP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_acquisition_scheduler.sv
// Directed bench for acquisition_scheduler with LENGTH=16. Expected start,
// capture-rise and done cycles (relative to the arm cycle) are queued when a
// run is launched and consumed by a negedge monitor as the DUT produces them.
module tb_acquisition_scheduler;

    localparam int LENGTH   = 16;
    localparam int PERIOD_W = 16;
    localparam int FRAMES_W = 16;
    localparam int SKIP_W   = 8;

    logic                sink_clk = 1'b0;
    logic                reset_n;
    logic                arm, abort, buf_ready;
    logic [PERIOD_W-1:0] cfg_period;
    logic [FRAMES_W-1:0] cfg_frames;
    logic                sink_start, capturing, busy, done, overrun;
    logic [FRAMES_W-1:0] frame_cnt;
    logic [SKIP_W-1:0]   skip_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int cap_cnt = 0;
    int cap_base;
    logic cap_prev = 1'b0;

    int exp_start[$];
    int exp_cap[$];
    int exp_done[$];

    acquisition_scheduler #(
        .LENGTH(LENGTH), .PERIOD_W(PERIOD_W), .FRAMES_W(FRAMES_W), .SKIP_W(SKIP_W)
    ) dut (
        .sink_clk(sink_clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .cfg_period(cfg_period), .cfg_frames(cfg_frames), .buf_ready(buf_ready),
        .sink_start(sink_start), .capturing(capturing), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .skip_cnt(skip_cnt), .overrun(overrun)
    );

    always #5 sink_clk = ~sink_clk;

    always @(posedge sink_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every event must match the head of its queue
    always @(negedge sink_clk) begin
        if (sink_start) chk("start_cyc", cyc - t0, (exp_start.size() != 0) ? exp_start.pop_front() : -1);
        if (capturing && !cap_prev)
            chk("cap_rise_cyc", cyc - t0, (exp_cap.size() != 0) ? exp_cap.pop_front() : -1);
        if (done) chk("done_cyc", cyc - t0, (exp_done.size() != 0) ? exp_done.pop_front() : -1);
        if (capturing) cap_cnt <= cap_cnt + 1;
        cap_prev <= capturing;
    end

    task automatic wait_rel(input int k);
        while ((cyc - t0) < k) begin
            @(posedge sink_clk);
            #1;
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        t0  = cyc;
        cap_base = cap_cnt;
        @(posedge sink_clk); #1;
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge sink_clk); #1;
        abort = 1'b0;
    endtask

    task automatic chk_queues(input string tag);
        chk({tag, "_start_q"}, exp_start.size(), 0);
        chk({tag, "_cap_q"},   exp_cap.size(),   0);
        chk({tag, "_done_q"},  exp_done.size(),  0);
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; buf_ready = 1'b1;
        cfg_period = 16'd40; cfg_frames = 16'd3;
        repeat (3) @(posedge sink_clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", sink_start, 0);
        chk("rst_cap", capturing, 0);
        chk("rst_done", done, 0);
        chk("rst_frame", 32'(frame_cnt), 0);
        chk("rst_skip", 32'(skip_cnt), 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        @(posedge sink_clk); #1;

        // 1: three frames, period 40, buffer always ready
        exp_start = '{2, 42, 82}; exp_cap = '{3, 43, 83}; exp_done = '{99};
        do_arm();
        chk("t1_busy_c1", busy, 1);
        wait_rel(110);
        chk("t1_frame", 32'(frame_cnt), 3);
        chk("t1_skip", 32'(skip_cnt), 0);
        chk("t1_ovr", overrun, 0);
        chk("t1_busy", busy, 0);
        chk("t1_capcycles", cap_cnt - cap_base, 48);
        chk_queues("t1");

        // 2: buffer not ready on the tick at cycle 41 only
        exp_start = '{2, 82, 122}; exp_cap = '{3, 83, 123}; exp_done = '{139};
        do_arm();
        chk("t2_cleared_frame", 32'(frame_cnt), 0);
        wait_rel(41); buf_ready = 1'b0;
        wait_rel(42); buf_ready = 1'b1;
        wait_rel(150);
        chk("t2_frame", 32'(frame_cnt), 3);
        chk("t2_skip", 32'(skip_cnt), 1);
        chk("t2_ovr", overrun, 1);
        chk_queues("t2");

        // 3: continuous mode, period 10 -> one skipped tick per frame
        cfg_period = 16'd10; cfg_frames = 16'd0;
        exp_start = '{2, 22, 42, 62, 82, 102};
        exp_cap   = '{3, 23, 43, 63, 83, 103};
        do_arm();
        chk("t3_cleared_skip", 32'(skip_cnt), 0);
        chk("t3_cleared_ovr", overrun, 0);
        for (int k = 1; k <= 105; k++) begin
            wait_rel(k);
            chk("t3_busy", busy, 1);
        end
        chk("t3_frame", 32'(frame_cnt), 5);
        chk("t3_skip", 32'(skip_cnt), 5);
        chk("t3_ovr", overrun, 1);
        do_abort();
        chk("t3_abort_busy", busy, 0);
        chk("t3_abort_cap", capturing, 0);
        wait_rel(140);
        chk("t3_hold_frame", 32'(frame_cnt), 5);
        chk("t3_hold_skip", 32'(skip_cnt), 5);
        chk("t3_hold_ovr", overrun, 1);
        chk_queues("t3");

        // 4: abort mid-capture at cycle 10
        cfg_period = 16'd40; cfg_frames = 16'd3;
        exp_start = '{2}; exp_cap = '{3};
        do_arm();
        wait_rel(10);
        chk("t4_cap_c10", capturing, 1);
        do_abort();
        chk("t4_cap_c11", capturing, 0);
        chk("t4_busy_c11", busy, 0);
        wait_rel(60);
        chk("t4_frame", 32'(frame_cnt), 0);
        chk("t4_busy", busy, 0);
        chk_queues("t4");

        // 5a: arm and abort together -> stays idle
        arm = 1'b1; abort = 1'b1; t0 = cyc;
        @(posedge sink_clk); #1;
        arm = 1'b0; abort = 1'b0;
        chk("t5_armabort_c1", busy, 0);
        wait_rel(6);
        chk("t5_armabort_c6", busy, 0);

        // 5b: re-arm while running with different config is ignored
        exp_start = '{2, 42, 82}; exp_cap = '{3, 43, 83};
        do_arm();
        wait_rel(20);
        cfg_period = 16'd7; cfg_frames = 16'd1; arm = 1'b1;
        @(posedge sink_clk); #1;
        arm = 1'b0;
        chk("t5_rearm_busy", busy, 1);
        wait_rel(90);
        chk("t5_cap_c90", capturing, 1);
        do_abort();
        chk("t5_frame", 32'(frame_cnt), 2);
        chk("t5_skip", 32'(skip_cnt), 0);
        wait_rel(110);
        chk_queues("t5");

        // 6: asynchronous reset mid-capture
        cfg_period = 16'd10; cfg_frames = 16'd0;
        exp_start = '{2, 22}; exp_cap = '{3, 23};
        do_arm();
        wait_rel(25);
        chk("t6_cap_pre", capturing, 1);
        chk("t6_frame_pre", 32'(frame_cnt), 1);
        chk("t6_skip_pre", 32'(skip_cnt), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_cap", capturing, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frame", 32'(frame_cnt), 0);
        chk("t6_rst_skip", 32'(skip_cnt), 0);
        chk("t6_rst_ovr", overrun, 0);
        repeat (3) @(posedge sink_clk);
        #1 reset_n = 1'b1;
        wait_rel(45);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_frame", 32'(frame_cnt), 0);
        chk_queues("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
